// File: rtl/serial_byte_tx.sv
// serial_byte_tx: valid/ready byte intake, MSB-first serial output with a shift strobe for an 8-bit shift register.
// Optional one-byte holding buffer is enabled by defining SERIAL_BYTE_TX_BUFFER_EN.
module serial_byte_tx #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       DATA_VALID,
    input  logic [7:0] DATA_BYTE,
    output logic       DATA_READY,
    output logic       DATA_OUT,
    output logic       SHIFT_ENABLE,
    output logic       BYTE_DONE,
    output logic       BUSY
);

    localparam int unsigned   PW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PW-1:0] PER_LAST = PW'(CLKS_PER_BIT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      tx;
    logic [7:0]      tx_nxt;
    logic [2:0]      bit_cnt;
    logic [2:0]      bit_cnt_nxt;
    logic [PW-1:0]   per_cnt;
    logic [PW-1:0]   per_cnt_nxt;
    logic            data_out_nxt;
    logic            shift_en_nxt;
    logic            busy_nxt;
    logic            accept;
    logic            bit_end;
    logic            byte_end;
`ifdef SERIAL_BYTE_TX_BUFFER_EN
    logic [7:0]      buf_q;
    logic [7:0]      buf_q_nxt;
    logic            buf_full;
    logic            buf_full_nxt;

    assign DATA_READY = RESET & ~buf_full;
`else
    assign DATA_READY = RESET & (state == IDLE);
`endif

    assign accept   = DATA_VALID & DATA_READY;
    assign bit_end  = (state == SHIFT) && (per_cnt == PER_LAST);
    assign byte_end = bit_end && (bit_cnt == 3'd7);

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a finished byte chains straight into the next one when one is available
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (byte_end) begin
`ifdef SERIAL_BYTE_TX_BUFFER_EN
                    if (!(buf_full || accept)) begin
                        state_nxt = IDLE;
                    end
`else
                    state_nxt = IDLE;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and output next values; outputs are registered from the post-edge state
    always_comb begin
        tx_nxt      = tx;
        bit_cnt_nxt = bit_cnt;
        per_cnt_nxt = per_cnt;
`ifdef SERIAL_BYTE_TX_BUFFER_EN
        buf_q_nxt    = buf_q;
        buf_full_nxt = buf_full;
`endif
        if (state == IDLE) begin
            if (accept) begin
                tx_nxt      = DATA_BYTE;
                bit_cnt_nxt = 3'd0;
                per_cnt_nxt = '0;
            end
        end else begin
            if (bit_end) begin
                tx_nxt      = {tx[6:0], 1'b0};
                bit_cnt_nxt = bit_cnt + 3'd1;
                per_cnt_nxt = '0;
            end else begin
                per_cnt_nxt = per_cnt + PW'(1);
            end
`ifdef SERIAL_BYTE_TX_BUFFER_EN
            if (byte_end && buf_full) begin
                tx_nxt       = buf_q;
                buf_full_nxt = 1'b0;
            end else if (byte_end && accept) begin
                tx_nxt = DATA_BYTE;
            end else if (accept) begin
                buf_q_nxt    = DATA_BYTE;
                buf_full_nxt = 1'b1;
            end
`endif
        end

        data_out_nxt = (state_nxt == SHIFT) && tx_nxt[7];
        shift_en_nxt = (state_nxt == SHIFT) && (per_cnt_nxt == PER_LAST);
`ifdef SERIAL_BYTE_TX_BUFFER_EN
        busy_nxt     = (state_nxt == SHIFT) || buf_full_nxt;
`else
        busy_nxt     = (state_nxt == SHIFT);
`endif
    end

    // Datapath and registered outputs
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            tx           <= '0;
            bit_cnt      <= '0;
            per_cnt      <= '0;
            DATA_OUT     <= 1'b0;
            SHIFT_ENABLE <= 1'b0;
            BYTE_DONE    <= 1'b0;
            BUSY         <= 1'b0;
`ifdef SERIAL_BYTE_TX_BUFFER_EN
            buf_q        <= '0;
            buf_full     <= 1'b0;
`endif
        end else begin
            tx           <= tx_nxt;
            bit_cnt      <= bit_cnt_nxt;
            per_cnt      <= per_cnt_nxt;
            DATA_OUT     <= data_out_nxt;
            SHIFT_ENABLE <= shift_en_nxt;
            BYTE_DONE    <= byte_end;
            BUSY         <= busy_nxt;
`ifdef SERIAL_BYTE_TX_BUFFER_EN
            buf_q        <= buf_q_nxt;
            buf_full     <= buf_full_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_serial_byte_tx.sv
// Bench for serial_byte_tx: N=1 and N=4 instances, each feeding a model of the downstream shift register.
// Expectations follow the buffered build when SERIAL_BYTE_TX_BUFFER_EN is defined.
module tb_serial_byte_tx;

`ifdef SERIAL_BYTE_TX_BUFFER_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       v1 = 1'b0;
    logic       v4 = 1'b0;
    logic [7:0] b1 = 8'h00;
    logic [7:0] b4 = 8'h00;
    logic       rdy1, do1, se1, done1, busy1;
    logic       rdy4, do4, se4, done4, busy4;
    logic [7:0] q1 = 8'h00;
    logic [7:0] q4 = 8'h00;

    logic       exp_bits1[$];
    logic       exp_bits4[$];
    logic [7:0] exp_bytes1[$];
    logic [7:0] exp_bytes4[$];
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    // Downstream 8-bit shift registers
    always @(posedge clk) if (se1) q1 <= {q1[6:0], do1};
    always @(posedge clk) if (se4) q4 <= {q4[6:0], do4};

    serial_byte_tx #(.CLKS_PER_BIT(1)) dut1 (
        .CLK(clk), .RESET(rst), .DATA_VALID(v1), .DATA_BYTE(b1), .DATA_READY(rdy1),
        .DATA_OUT(do1), .SHIFT_ENABLE(se1), .BYTE_DONE(done1), .BUSY(busy1)
    );

    serial_byte_tx #(.CLKS_PER_BIT(4)) dut4 (
        .CLK(clk), .RESET(rst), .DATA_VALID(v4), .DATA_BYTE(b4), .DATA_READY(rdy4),
        .DATA_OUT(do4), .SHIFT_ENABLE(se4), .BYTE_DONE(done4), .BUSY(busy4)
    );

    task automatic push_byte1(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_bits1.push_back(b[i]);
        exp_bytes1.push_back(b);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        vectors++;
        if ({do1, se1, done1, busy1, rdy1, do4, se4, done4, busy4, rdy4} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {do1, se1, done1, busy1, rdy1, do4, se4, done4, busy4, rdy4}, 10'b0);
        end
        rst = 1'b1; #1;
        vectors++;
        if ({rdy1, rdy4} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b expected 11", {rdy1, rdy4});
        end
    endtask

    // One byte through the N=1 instance; noise pulses DATA_VALID while busy (unbuffered build)
    task automatic send_byte1(input logic [7:0] b, input bit noise);
        logic       bit_exp;
        logic [4:0] got, exp;
        logic [7:0] byte_exp;
        @(negedge clk); #1;
        vectors++;
        if (rdy1 !== 1'b1) begin
            miscompares++;
            $display("FAIL send1_ready: got %b expected 1", rdy1);
        end
        v1 = 1'b1;
        b1 = b;
        push_byte1(b);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            v1 = (noise && !BUF_EN && c <= 8) ? 1'($urandom_range(0, 1)) : 1'b0;
            b1 = 8'($urandom);
            #1;
            bit_exp = 1'b0;
            if (c <= 8 && exp_bits1.size() > 0) bit_exp = exp_bits1.pop_front();
            exp = (c <= 8) ? {bit_exp, 1'b1, 1'b0, 1'b1, BUF_EN} : 5'b00101;
            got = {do1, se1, done1, busy1, rdy1};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL send1 byte %h cycle %0d {out,se,done,busy,ready}: got %b expected %b", b, c, got, exp);
            end
            if (done1 === 1'b1) begin
                vectors++;
                if (exp_bytes1.size() == 0) begin
                    miscompares++;
                    $display("FAIL send1_q: unexpected BYTE_DONE at cycle %0d", c);
                end else begin
                    byte_exp = exp_bytes1.pop_front();
                    if (q1 !== byte_exp) begin
                        miscompares++;
                        $display("FAIL send1_q: got %h expected %h", q1, byte_exp);
                    end
                end
            end
        end
    endtask

    task automatic test_single();
        send_byte1(8'hA5, 1'b0);
    endtask

    task automatic test_slow_bits();
        logic       se_exp, shifting, do_exp;
        logic [5:0] got, exp;
        logic [7:0] byte_exp;
        @(negedge clk); #1;
        v4 = 1'b1;
        b4 = 8'h3C;
        for (int i = 7; i >= 0; i--) exp_bits4.push_back(b4[i]);
        exp_bytes4.push_back(8'h3C);
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            v4 = 1'b0;
            b4 = 8'($urandom);
            #1;
            shifting = (c <= 32);
            se_exp   = shifting && (c % 4 == 0);
            do_exp   = (shifting && exp_bits4.size() > 0) ? exp_bits4[0] : 1'b0;
            exp = {do_exp, se_exp, c == 33, shifting, shifting ? BUF_EN : 1'b1, 1'b0};
            got = {do4, se4, done4, busy4, rdy4, 1'b0};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL n4 cycle %0d {out,se,done,busy,ready,0}: got %b expected %b", c, got, exp);
            end
            if (se_exp && exp_bits4.size() > 0) void'(exp_bits4.pop_front());
            if (done4 === 1'b1) begin
                vectors++;
                if (exp_bytes4.size() == 0) begin
                    miscompares++;
                    $display("FAIL n4_q: unexpected BYTE_DONE at cycle %0d", c);
                end else begin
                    byte_exp = exp_bytes4.pop_front();
                    if (q4 !== byte_exp) begin
                        miscompares++;
                        $display("FAIL n4_q: got %h expected %h", q4, byte_exp);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int         acc;
        int         last;
        bit         pending;
        logic       bit_exp, se_exp, done_exp, rdy_exp;
        logic [4:0] got, exp;
        logic [7:0] byte_exp;
        last = BUF_EN ? 17 : 18;
        acc = -1;
        @(negedge clk); #1;
        v1 = 1'b1;
        b1 = 8'hFF;
        push_byte1(8'hFF);
        pending = 1'b1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (pending) begin
                b1 = 8'h00;
            end else begin
                v1 = 1'b0;
                b1 = 8'($urandom);
            end
            #1;
            if (BUF_EN) begin
                se_exp   = (c <= 16);
                done_exp = (c == 9) || (c == 17);
                rdy_exp  = (c == 1) || (c >= 9);
            end else begin
                se_exp   = (c <= 8) || (c >= 10 && c <= 17);
                done_exp = (c == 9) || (c == 18);
                rdy_exp  = !se_exp;
            end
            bit_exp = 1'b0;
            if (se_exp && exp_bits1.size() > 0) bit_exp = exp_bits1.pop_front();
            exp = {bit_exp, se_exp, done_exp, se_exp, rdy_exp};
            got = {do1, se1, done1, busy1, rdy1};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL b2b cycle %0d {out,se,done,busy,ready}: got %b expected %b", c, got, exp);
            end
            if (done1 === 1'b1) begin
                vectors++;
                if (exp_bytes1.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_q: unexpected BYTE_DONE at cycle %0d", c);
                end else begin
                    byte_exp = exp_bytes1.pop_front();
                    if (q1 !== byte_exp) begin
                        miscompares++;
                        $display("FAIL b2b_q: got %h expected %h", q1, byte_exp);
                    end
                end
            end
            if (pending && v1 && rdy1) begin
                push_byte1(8'h00);
                pending = 1'b0;
                acc = c;
            end
        end
        v1 = 1'b0;
        vectors++;
        if (acc != (BUF_EN ? 1 : 9)) begin
            miscompares++;
            $display("FAIL b2b_accept_cycle: got %0d expected %0d", acc, BUF_EN ? 1 : 9);
        end
    endtask

    task automatic test_valid_while_busy();
        send_byte1(8'h5A, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            vectors++;
            if ({se1, done1, busy1, rdy1} !== 4'b0001) begin
                miscompares++;
                $display("FAIL busy_noise_tail cycle %0d {se,done,busy,ready}: got %b expected 0001",
                         c, {se1, done1, busy1, rdy1});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic bit_exp;
        @(negedge clk); #1;
        v1 = 1'b1;
        b1 = 8'hC3;
        push_byte1(8'hC3);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            v1 = 1'b0;
            b1 = 8'($urandom);
            #1;
            bit_exp = (exp_bits1.size() > 0) ? exp_bits1.pop_front() : 1'b0;
            vectors++;
            if ({do1, se1} !== {bit_exp, 1'b1}) begin
                miscompares++;
                $display("FAIL rst_mid_bits cycle %0d: got %b expected %b", c, {do1, se1}, {bit_exp, 1'b1});
            end
        end
        @(negedge clk);
        rst = 1'b0; #1;
        vectors++;
        if ({rdy1, rdy4} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_mid_ready_low: got %b expected 00", {rdy1, rdy4});
        end
        @(negedge clk); #1;
        vectors++;
        if ({do1, se1, done1, busy1, rdy1} !== 5'b0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got %b expected 00000", {do1, se1, done1, busy1, rdy1});
        end
        rst = 1'b1;
        exp_bits1.delete();
        exp_bytes1.delete();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            vectors++;
            if ({se1, done1, busy1} !== 3'b000) begin
                miscompares++;
                $display("FAIL rst_mid_quiet cycle %0d {se,done,busy}: got %b expected 000", c, {se1, done1, busy1});
            end
        end
        send_byte1(8'h81, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_slow_bits();
        test_back_to_back();
        test_valid_while_busy();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
